// File: rtl/cra_pkg.sv
// Shared CRA board definitions: CRAM address width, call-stack depth,
// the CRAM address type and the call-stack operation encoding.
package cra_pkg;

    localparam int unsigned CRA_ADR_W     = 11;
    localparam int unsigned CRA_STK_DEPTH = 16;

    typedef logic [CRA_ADR_W-1:0] cra_adr_t;

    typedef enum logic [2:0] {
        STK_IDLE,
        STK_PUSH,
        STK_POP,
        STK_SWAP,
        STK_CLR
    } stk_op_t;

endpackage

// File: rtl/cra_stk_ram.sv
// Call-stack entry storage: DEPTH x W register file, one synchronous write
// port and one asynchronous read port. The array has no reset.
// Ports:
//   clk    in   write clock
//   we     in   write enable
//   waddr  in   write index
//   wdata  in   write data
//   raddr  in   read index
//   rdata  out  read data (combinational)
module cra_stk_ram #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned W     = 11,
    localparam int unsigned IW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [IW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [IW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/cra_call_stack.sv
// Microcode subroutine return stack. CALL saves the current CRAM address,
// RETURN exposes the saved one; a simultaneous CALL+RETURN replaces the top.
// Pointer and flags saturate and are sticky; a diagnostic EBUS read returns
// {top, 0, perr, unf, ovf, count} and drives zero when not selected.
// Optional feature: define CRA_STK_PAR_EN to store and check odd parity per
// entry; otherwise cra_stk_perr_h and EBUS bit 7 are tied 0.
// Ports:
//   clk_cra_h        in   board clock
//   mr_reset_l       in   asynchronous active-low master reset
//   cra_call_h       in   push request
//   cra_ret_h        in   pop request
//   cra_adr_h        in   address saved on call
//   diag_stk_clr_l   in   synchronous clear of pointer and flags (active low)
//   diag_read_stk_l  in   EBUS drive enable (active low)
//   cra_stk_adr_h    out  top-of-stack address, 0 when empty
//   cra_stk_valid_h  out  stack non-empty
//   cra_stk_ovf_h    out  sticky overflow
//   cra_stk_unf_h    out  sticky underflow
//   cra_stk_perr_h   out  sticky parity error
//   ebus_stk_e_h     out  diagnostic read data
module cra_call_stack
    import cra_pkg::*;
#(
    parameter int unsigned DEPTH = CRA_STK_DEPTH,
    parameter int unsigned AW    = CRA_ADR_W
) (
    input  logic          clk_cra_h,
    input  logic          mr_reset_l,
    input  logic          cra_call_h,
    input  logic          cra_ret_h,
    input  logic [AW-1:0] cra_adr_h,
    input  logic          diag_stk_clr_l,
    input  logic          diag_read_stk_l,
    output logic [AW-1:0] cra_stk_adr_h,
    output logic          cra_stk_valid_h,
    output logic          cra_stk_ovf_h,
    output logic          cra_stk_unf_h,
    output logic          cra_stk_perr_h,
    output logic [19:0]   ebus_stk_e_h
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned IW = $clog2(DEPTH);
`ifdef CRA_STK_PAR_EN
    localparam int unsigned RW = AW + 1;
`else
    localparam int unsigned RW = AW;
`endif

    stk_op_t        op;
    logic [CW-1:0]  count_q, count_d, count_m1;
    logic           ovf_q, ovf_d, unf_q, unf_d;
    logic           perr;
    logic           we;
    logic [IW-1:0]  waddr;
    logic [RW-1:0]  wdata, rdata;
    logic [AW-1:0]  top;
    logic           non_empty;

    assign count_m1  = count_q - CW'(1);
    assign non_empty = (count_q != '0);

    always_comb begin
        op = STK_IDLE;
        if (!diag_stk_clr_l) begin
            op = STK_CLR;
        end else begin
            unique case ({cra_call_h, cra_ret_h})
                2'b10:   op = STK_PUSH;
                2'b01:   op = STK_POP;
                2'b11:   op = STK_SWAP;
                default: op = STK_IDLE;
            endcase
        end
    end

    always_comb begin
        count_d = count_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        we      = 1'b0;
        waddr   = count_q[IW-1:0];
        unique case (op)
            STK_CLR: begin
                count_d = '0;
                ovf_d   = 1'b0;
                unf_d   = 1'b0;
            end
            STK_PUSH: begin
                if (count_q < CW'(DEPTH)) begin
                    we      = 1'b1;
                    count_d = count_q + CW'(1);
                end else begin
                    ovf_d = 1'b1;
                end
            end
            STK_POP: begin
                if (non_empty) begin
                    count_d = count_m1;
                end else begin
                    unf_d = 1'b1;
                end
            end
            STK_SWAP: begin
                // Empty swap degenerates to a push into slot 0 without underflow.
                we = 1'b1;
                if (non_empty) begin
                    waddr = count_m1[IW-1:0];
                end else begin
                    count_d = CW'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_cra_h or negedge mr_reset_l) begin
        if (!mr_reset_l) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

`ifdef CRA_STK_PAR_EN
    logic perr_q, perr_d;

    // Odd parity: stored word (data + parity bit) must hold an odd number of ones.
    assign wdata = {~^cra_adr_h, cra_adr_h};

    always_comb begin
        perr_d = perr_q;
        if (op == STK_CLR) begin
            perr_d = 1'b0;
        end else if (non_empty && !(^rdata)) begin
            perr_d = 1'b1;
        end
    end

    always_ff @(posedge clk_cra_h or negedge mr_reset_l) begin
        if (!mr_reset_l) begin
            perr_q <= 1'b0;
        end else begin
            perr_q <= perr_d;
        end
    end

    assign perr = perr_q;
`else
    assign wdata = cra_adr_h;
    assign perr  = 1'b0;
`endif

    cra_stk_ram #(
        .DEPTH (DEPTH),
        .W     (RW)
    ) u_ram (
        .clk   (clk_cra_h),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .raddr (count_m1[IW-1:0]),
        .rdata (rdata)
    );

    assign top             = non_empty ? rdata[AW-1:0] : '0;
    assign cra_stk_adr_h   = top;
    assign cra_stk_valid_h = non_empty;
    assign cra_stk_ovf_h   = ovf_q;
    assign cra_stk_unf_h   = unf_q;
    assign cra_stk_perr_h  = perr;

    always_comb begin
        ebus_stk_e_h = '0;
        if (!diag_read_stk_l) begin
            ebus_stk_e_h[4:0]  = 5'(count_q);
            ebus_stk_e_h[5]    = ovf_q;
            ebus_stk_e_h[6]    = unf_q;
            ebus_stk_e_h[7]    = perr;
            ebus_stk_e_h[19:9] = 11'(top);
        end
    end

endmodule

// File: tb/tb_cra_call_stack.sv
// Self-checking bench for cra_call_stack: directed scenarios plus randomized
// op sequences, all checked against a queue-based reference stack.
module tb_cra_call_stack;
    import cra_pkg::*;

    localparam int AW    = 11;
    localparam int DEPTH = 16;
    localparam int VW    = AW + 4 + 20;

    logic          clk_cra_h = 1'b0;
    logic          mr_reset_l = 1'b0;
    logic          cra_call_h = 1'b0;
    logic          cra_ret_h = 1'b0;
    logic [AW-1:0] cra_adr_h = '0;
    logic          diag_stk_clr_l = 1'b1;
    logic          diag_read_stk_l = 1'b0;
    logic [AW-1:0] cra_stk_adr_h;
    logic          cra_stk_valid_h, cra_stk_ovf_h, cra_stk_unf_h, cra_stk_perr_h;
    logic [19:0]   ebus_stk_e_h;

    cra_call_stack #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk_cra_h       (clk_cra_h),
        .mr_reset_l      (mr_reset_l),
        .cra_call_h      (cra_call_h),
        .cra_ret_h       (cra_ret_h),
        .cra_adr_h       (cra_adr_h),
        .diag_stk_clr_l  (diag_stk_clr_l),
        .diag_read_stk_l (diag_read_stk_l),
        .cra_stk_adr_h   (cra_stk_adr_h),
        .cra_stk_valid_h (cra_stk_valid_h),
        .cra_stk_ovf_h   (cra_stk_ovf_h),
        .cra_stk_unf_h   (cra_stk_unf_h),
        .cra_stk_perr_h  (cra_stk_perr_h),
        .ebus_stk_e_h    (ebus_stk_e_h)
    );

    always #5 clk_cra_h = ~clk_cra_h;

    int vectors = 0;
    int errors  = 0;

    // Reference model: the queue's last element is the top of stack.
    logic [AW-1:0] m_stk[$];
    bit m_ovf = 0, m_unf = 0, m_perr = 0;

    function automatic void model_clear();
        m_stk.delete();
        m_ovf  = 0;
        m_unf  = 0;
        m_perr = 0;
    endfunction

    function automatic void model_op(bit call, bit ret, bit clr_n, logic [AW-1:0] adr);
        if (!clr_n) begin
            model_clear();
        end else if (call && !ret) begin
            if (m_stk.size() < DEPTH) m_stk.push_back(adr);
            else m_ovf = 1;
        end else if (!call && ret) begin
            if (m_stk.size() > 0) void'(m_stk.pop_back());
            else m_unf = 1;
        end else if (call && ret) begin
            // Return-then-call; on an empty stack the return half does nothing.
            if (m_stk.size() > 0) void'(m_stk.pop_back());
            m_stk.push_back(adr);
        end
    endfunction

    function automatic logic [AW-1:0] m_top();
        return (m_stk.size() > 0) ? m_stk[m_stk.size()-1] : '0;
    endfunction

    function automatic logic [VW-1:0] exp_vec();
        logic [19:0] eb;
        int n;
        n  = m_stk.size();
        eb = '0;
        if (!diag_read_stk_l) eb = {m_top(), 1'b0, m_perr, m_unf, m_ovf, 5'(n)};
        return {m_top(), (n > 0), m_ovf, m_unf, m_perr, eb};
    endfunction

    function automatic logic [VW-1:0] obs_vec();
        return {cra_stk_adr_h, cra_stk_valid_h, cra_stk_ovf_h, cra_stk_unf_h,
                cra_stk_perr_h, ebus_stk_e_h};
    endfunction

    // Apply one op across a rising edge; returns at the following falling edge.
    task automatic step(input bit call, input bit ret, input bit clr_n,
                        input logic [AW-1:0] adr);
        cra_call_h     = call;
        cra_ret_h      = ret;
        diag_stk_clr_l = clr_n;
        cra_adr_h      = adr;
        @(posedge clk_cra_h);
        model_op(call, ret, clr_n, adr);
        @(negedge clk_cra_h);
        cra_call_h     = 1'b0;
        cra_ret_h      = 1'b0;
        diag_stk_clr_l = 1'b1;
    endtask

    task automatic test_reset();
        mr_reset_l = 1'b0;
        diag_read_stk_l = 1'b0;
        #12;
        model_clear();
        vectors++;
        if (obs_vec() !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0", obs_vec());
        end
        @(negedge clk_cra_h);
        mr_reset_l = 1'b1;
        @(negedge clk_cra_h);
        vectors++;
        if (obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL reset_release: got %h expected %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_push_pop();
        step(1, 0, 1, 11'o1234);
        step(1, 0, 1, 11'o0017);
        step(1, 0, 1, 11'o2000);
        vectors++;
        if (cra_stk_adr_h !== 11'o2000 || ebus_stk_e_h[4:0] !== 5'd3) begin
            errors++;
            $display("FAIL push3: got top=%o count=%0d expected top=2000 count=3",
                     cra_stk_adr_h, ebus_stk_e_h[4:0]);
        end
        step(0, 1, 1, '0);
        vectors++;
        if (cra_stk_adr_h !== 11'o0017 || obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL pop_after_push: got %h expected %h", obs_vec(), exp_vec());
        end
        step(0, 0, 0, '0);
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= DEPTH; i++) step(1, 0, 1, AW'(i));
        step(1, 0, 1, 11'o777);
        vectors++;
        if (cra_stk_ovf_h !== 1'b1 || ebus_stk_e_h[4:0] !== 5'd16 ||
            cra_stk_adr_h !== 11'd16) begin
            errors++;
            $display("FAIL overflow: got ovf=%b count=%0d top=%0d expected 1 16 16",
                     cra_stk_ovf_h, ebus_stk_e_h[4:0], cra_stk_adr_h);
        end
        for (int i = 0; i < DEPTH; i++) begin
            step(0, 1, 1, '0);
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL drain_pop%0d: got %h expected %h", i, obs_vec(), exp_vec());
            end
        end
        vectors++;
        if (cra_stk_valid_h !== 1'b0 || cra_stk_adr_h !== '0) begin
            errors++;
            $display("FAIL drained: got valid=%b top=%o expected 0 0",
                     cra_stk_valid_h, cra_stk_adr_h);
        end
        step(0, 0, 0, '0);
    endtask

    task automatic test_underflow();
        step(0, 1, 1, '0);
        vectors++;
        if (cra_stk_unf_h !== 1'b1 || ebus_stk_e_h[4:0] !== 5'd0) begin
            errors++;
            $display("FAIL underflow: got unf=%b count=%0d expected 1 0",
                     cra_stk_unf_h, ebus_stk_e_h[4:0]);
        end
        step(1, 0, 0, 11'o55);
        vectors++;
        if (cra_stk_unf_h !== 1'b0 || obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL clr_overrides: got %h expected %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_swap();
        step(1, 0, 1, 11'o100);
        step(1, 1, 1, 11'o200);
        vectors++;
        if (cra_stk_adr_h !== 11'o200 || ebus_stk_e_h[4:0] !== 5'd1) begin
            errors++;
            $display("FAIL swap: got top=%o count=%0d expected 200 1",
                     cra_stk_adr_h, ebus_stk_e_h[4:0]);
        end
        step(0, 0, 0, '0);
        step(1, 1, 1, 11'd5);
        vectors++;
        if (cra_stk_adr_h !== 11'd5 || ebus_stk_e_h[4:0] !== 5'd1 ||
            cra_stk_unf_h !== 1'b0) begin
            errors++;
            $display("FAIL swap_empty: got top=%0d count=%0d unf=%b expected 5 1 0",
                     cra_stk_adr_h, ebus_stk_e_h[4:0], cra_stk_unf_h);
        end
        step(0, 0, 0, '0);
    endtask

    task automatic test_ebus();
        logic [19:0] want;
        want = {11'o42, 9'd0} | 20'h22;
        step(1, 0, 1, 11'o1);
        step(1, 0, 1, 11'o42);
        for (int i = 0; i < DEPTH - 1; i++) step(1, 0, 1, AW'(100 + i));
        for (int i = 0; i < DEPTH - 2; i++) step(0, 1, 1, '0);
        diag_read_stk_l = 1'b0;
        #1;
        vectors++;
        if (ebus_stk_e_h !== want) begin
            errors++;
            $display("FAIL ebus_read: got %h expected %h", ebus_stk_e_h, want);
        end
        diag_read_stk_l = 1'b1;
        #1;
        vectors++;
        if (ebus_stk_e_h !== 20'h0) begin
            errors++;
            $display("FAIL ebus_idle: got %h expected 0", ebus_stk_e_h);
        end
        diag_read_stk_l = 1'b0;
        step(0, 0, 0, '0);
    endtask

    task automatic test_random();
        bit call, ret, clr_n;
        for (int i = 0; i < 600; i++) begin
            clr_n = ($urandom_range(0, 99) >= 3);
            call  = ($urandom_range(0, 99) < 55);
            ret   = ($urandom_range(0, 99) < 45);
            diag_read_stk_l = $urandom_range(0, 1);
            step(call, ret, clr_n, AW'($urandom));
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL random%0d: got %h expected %h", i, obs_vec(), exp_vec());
            end
        end
        diag_read_stk_l = 1'b0;
    endtask

    task automatic test_reset_mid_push();
        step(1, 0, 1, 11'o321);
        step(1, 0, 1, 11'o456);
        cra_call_h = 1'b1;
        cra_adr_h  = 11'o7;
        #2;
        mr_reset_l = 1'b0;
        #1;
        model_clear();
        vectors++;
        if (obs_vec() !== '0) begin
            errors++;
            $display("FAIL reset_mid_push: got %h expected 0", obs_vec());
        end
        cra_call_h = 1'b0;
        @(negedge clk_cra_h);
        mr_reset_l = 1'b1;
        step(0, 1, 1, '0);
        vectors++;
        if (cra_stk_unf_h !== 1'b1 || obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL pop_after_reset: got %h expected %h", obs_vec(), exp_vec());
        end
        step(0, 0, 0, '0);
    endtask

`ifdef CRA_STK_PAR_EN
    task automatic test_parity();
        step(1, 0, 1, 11'o12);
        step(1, 0, 1, 11'o34);
        dut.u_ram.mem[1][0] = ~dut.u_ram.mem[1][0];
        @(posedge clk_cra_h);
        @(negedge clk_cra_h);
        vectors++;
        if (cra_stk_perr_h !== 1'b1) begin
            errors++;
            $display("FAIL parity_err: got perr=%b expected 1", cra_stk_perr_h);
        end
        step(0, 0, 0, '0);
    endtask
`endif

    initial begin
        test_reset();
        test_push_pop();
        test_overflow();
        test_underflow();
        test_swap();
        test_ebus();
        test_random();
        test_reset_mid_push();
`ifdef CRA_STK_PAR_EN
        test_parity();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
